serial_sub: RTL and testbench

//  Bit-serial subtractor: computes Diff = A - B - Bin and borrow-out Bout, one bit per clock, LSB first.
//  It is the inverse-operation companion to the parallel 4-bit ripple adder (A + B + Cin).

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_sub_full_sub.sv | 16 +
 rtl/serial_sub.sv | 126 ++++++++++++
 tb/tb_serial_sub.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encodings and default operand width.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Reference borrow of a 1-bit full subtractor.
  function automatic logic fs_borrow(
    input logic a,
    input logic b,
    input logic br
  );
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// Combinational 1-bit full subtractor.
// d = a - b - bin (mod 2), bout = borrow out.
module full_sub
  import serial_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Diff = A - B - Bin, Bout = borrow out of the MSB.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             fs_d;
  logic             fs_bout;

  // Current bit pair is always the LSB of the shifting operands.
  full_sub u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state logic: handshake, bit-serial datapath and result latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        r_d   = {fs_d, r_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = fs_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = {fs_d, r_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_comb begin
    ready_d = (state_d != ST_SHIFT);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign Diff  = diff_q;
  assign Bout  = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and exhaustive bench for serial_sub.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_serial_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic       ready;
  logic [3:0] Diff;
  logic       Bout;
  logic       done;

  int errs;
  int checks;

  serial_sub #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .Diff  (Diff),
    .Bout  (Bout),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one accepted edge, then wait for done.
  // lat = edges after the accepting edge until done is seen.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic bi, output int lat);
    A = a;
    B = b;
    Bin = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    Bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got=%b exp=1", ready);
    end
    checks++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    checks++;
    if (Diff !== 4'd0) begin
      errs++;
      $display("FAIL reset_diff got=%0d exp=0", Diff);
    end
    checks++;
    if (Bout !== 1'b0) begin
      errs++;
      $display("FAIL reset_bout got=%b exp=0", Bout);
    end
    tick();
  endtask

  task automatic test_basic();
    int lat;
    logic rdy_busy;
    A = 4'd5;
    B = 4'd3;
    Bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rdy_busy = ready;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (!done && ready !== 1'b0) rdy_busy = 1'b1;
    end
    checks++;
    if (rdy_busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_ready_busy got=%b exp=0", rdy_busy);
    end
    checks++;
    if (lat != 4) begin
      errs++;
      $display("FAIL basic_latency got=%0d exp=4", lat);
    end
    checks++;
    if (Diff !== 4'd2 || Bout !== 1'b0) begin
      errs++;
      $display("FAIL basic_result got=%0d/%b exp=2/0", Diff, Bout);
    end
    checks++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL basic_ready_done got=%b exp=1", ready);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL basic_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_borrow();
    int lat;
    run_op(4'd0, 4'd1, 1'b0, lat);
    checks++;
    if (lat != 4 || Diff !== 4'd15 || Bout !== 1'b1) begin
      errs++;
      $display("FAIL borrow_0m1 got=%0d/%b lat=%0d exp=15/1 lat=4",
               Diff, Bout, lat);
    end
    tick();
    run_op(4'd15, 4'd15, 1'b1, lat);
    checks++;
    if (lat != 4 || Diff !== 4'd15 || Bout !== 1'b1) begin
      errs++;
      $display("FAIL borrow_15m15m1 got=%0d/%b lat=%0d exp=15/1 lat=4",
               Diff, Bout, lat);
    end
    tick();
    run_op(4'd0, 4'd0, 1'b1, lat);
    checks++;
    if (lat != 4 || Diff !== 4'd15 || Bout !== 1'b1) begin
      errs++;
      $display("FAIL borrow_0m0m1 got=%0d/%b lat=%0d exp=15/1 lat=4",
               Diff, Bout, lat);
    end
    tick();
  endtask

  task automatic test_busy();
    int lat;
    int extra;
    A = 4'd5;
    B = 4'd3;
    Bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd9;
    B = 4'd0;
    Bin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || Diff !== 4'd2 || Bout !== 1'b0) begin
      errs++;
      $display("FAIL busy_ignore got=%0d/%b lat=%0d exp=2/0 lat=4",
               Diff, Bout, lat);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL busy_no_extra got=%0d/%b exp=0/1", extra, ready);
    end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    int bad;
    A = 4'd6;
    B = 4'd1;
    Bin = 1'b0;
    start = 1'b1;
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (done) begin
        pos.push_back(i);
        if (Diff !== 4'd5 || Bout !== 1'b0) bad++;
      end
    end
    start = 1'b0;
    checks++;
    if (pos.size() != 4) begin
      errs++;
      $display("FAIL b2b_count got=%0d exp=4", pos.size());
    end
    for (int i = 1; i < pos.size(); i++) begin
      checks++;
      if (pos[i] - pos[i-1] != 5) begin
        errs++;
        $display("FAIL b2b_period got=%0d exp=5", pos[i] - pos[i-1]);
      end
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL b2b_result got=%0d bad exp=0", bad);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    A = 4'd7;
    B = 4'd2;
    Bin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_flags got=%b/%b exp=1/0", ready, done);
    end
    checks++;
    if (Diff !== 4'd0 || Bout !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_out got=%0d/%b exp=0/0", Diff, Bout);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++;
      $display("FAIL rstmid_nodone got=%0d exp=0", seen);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_start got=%0d/%b exp=0/1", seen, ready);
    end
    run_op(4'd7, 4'd2, 1'b0, lat);
    checks++;
    if (lat != 4 || Diff !== 4'd5 || Bout !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_after got=%0d/%b lat=%0d exp=5/0 lat=4",
               Diff, Bout, lat);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int lat;
    logic [4:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp = {1'b0, 4'(a)} - {1'b0, 4'(b)} - {4'd0, 1'(c)};
          run_op(4'(a), 4'(b), 1'(c), lat);
          checks++;
          if (lat != 4 || {Bout, Diff} !== exp) begin
            errs++;
            $display("FAIL exh a=%0d b=%0d bin=%0d got=%h lat=%0d exp=%h",
                     a, b, c, {Bout, Diff}, lat, exp);
          end
        end
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    Bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
